// File: rtl/img_frame_buffer_pkg.sv
// img_frame_buffer_pkg
// Shared definitions for the input-image frame buffer: pixel type, frame
// geometry, read-address width, bias byte and the write-side state enum.
package img_frame_buffer_pkg;

    typedef logic [7:0] UINT_8;

    localparam int    NUM_PIX   = 256;
    localparam int    ADR_LEN   = 9;
    localparam int    IDX_W     = $clog2(NUM_PIX);
    localparam int    CNT_W     = $clog2(NUM_PIX + 1);
    localparam UINT_8 BIAS_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL
    } wr_state_e;

endpackage

// File: rtl/img_frame_buffer_if.sv
// img_frame_buffer_if
// Bundles the pixel stream (valid/sof/data/ready) and the network side
// (rd_adr/rd_byte, nn_start/nn_done/busy).
//   master : decimator + network side (drives pixels, read address, nn_done)
//   slave  : the frame buffer
interface img_frame_buffer_if;
    import img_frame_buffer_pkg::*;

    logic               pix_valid;
    logic               pix_sof;
    UINT_8              pix_data;
    logic               pix_ready;
    logic [ADR_LEN-1:0] rd_adr;
    UINT_8              rd_byte;
    logic               nn_start;
    logic               nn_done;
    logic               busy;

    modport master (
        output pix_valid, pix_sof, pix_data, rd_adr, nn_done,
        input  pix_ready, rd_byte, nn_start, busy
    );

    modport slave (
        input  pix_valid, pix_sof, pix_data, rd_adr, nn_done,
        output pix_ready, rd_byte, nn_start, busy
    );

endinterface

// File: rtl/img_frame_buffer_bank.sv
// img_bank
// One image bank: DEPTH x 8 RAM, synchronous write, combinational read.
// Ports: clk, we/wa/wd (write port), ra/rd (read port).
module img_bank
    import img_frame_buffer_pkg::*;
#(
    parameter int DEPTH = NUM_PIX,
    parameter int AW    = IDX_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  UINT_8         wd,
    input  logic [AW-1:0] ra,
    output UINT_8         rd
);

    UINT_8 mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd = mem[ra];

endmodule

// File: rtl/img_frame_buffer.sv
// img_frame_buffer
// Double-buffered 16x16 uint8 image store between the pixel decimator and the
// network input layer. One bank fills while the other is read; when a frame is
// complete and the network is idle the banks swap and nn_start pulses.
// Ports:
//   clk, reset  : system clock, asynchronous active-high reset
//   bus (slave) : pixel stream, network read port, nn_start/nn_done/busy
// Optional (macro FRAME_STATS_EN): frames_done[15:0], resyncs[7:0], drops[7:0]
// saturating event counters.
module img_frame_buffer
    import img_frame_buffer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    img_frame_buffer_if.slave  bus
`ifdef FRAME_STATS_EN
    ,
    output logic [15:0]        frames_done,
    output logic [7:0]         resyncs,
    output logic [7:0]         drops
`endif
);

    wr_state_e          state_q, state_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic               rd_bank_q, rd_bank_d;
    logic               busy_q, busy_d;
    logic               nn_start_q, nn_start_d;
    logic               pix_ready_q, pix_ready_d;

    logic               accept;
    logic               swap;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    UINT_8              bank0_rd, bank1_rd;

    assign accept = bus.pix_valid & pix_ready_q;
    assign swap   = (state_q == FULL) & ~busy_q;

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_bank_d   = rd_bank_q;
        busy_d      = busy_q;
        nn_start_d  = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = '0;

        case (state_q)
            IDLE: begin
                if (accept && bus.pix_sof) begin
                    wr_en    = 1'b1;
                    wr_cnt_d = CNT_W'(1);
                    state_d  = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (bus.pix_sof) begin
                        wr_cnt_d = CNT_W'(1);
                    end else begin
                        wr_idx   = IDX_W'(wr_cnt_q);
                        wr_cnt_d = wr_cnt_q + CNT_W'(1);
                        if (wr_cnt_q == CNT_W'(NUM_PIX - 1)) begin
                            state_d = FULL;
                        end
                    end
                end
            end
            FULL: begin
                if (swap) begin
                    rd_bank_d  = ~rd_bank_q;
                    busy_d     = 1'b1;
                    nn_start_d = 1'b1;
                    wr_cnt_d   = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Swap only happens with busy low, so the two busy updates never collide.
        if (busy_q && bus.nn_done) begin
            busy_d = 1'b0;
        end

        pix_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            busy_q      <= 1'b0;
            nn_start_q  <= 1'b0;
            pix_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_bank_q   <= rd_bank_d;
            busy_q      <= busy_d;
            nn_start_q  <= nn_start_d;
            pix_ready_q <= pix_ready_d;
        end
    end

    // Writes always target the bank the network is not reading.
    assign rd_idx = IDX_W'(bus.rd_adr - ADR_LEN'(1));

    img_bank #(.DEPTH(NUM_PIX), .AW(IDX_W)) u_bank0 (
        .clk (clk),
        .we  (wr_en & rd_bank_q),
        .wa  (wr_idx),
        .wd  (bus.pix_data),
        .ra  (rd_idx),
        .rd  (bank0_rd)
    );

    img_bank #(.DEPTH(NUM_PIX), .AW(IDX_W)) u_bank1 (
        .clk (clk),
        .we  (wr_en & ~rd_bank_q),
        .wa  (wr_idx),
        .wd  (bus.pix_data),
        .ra  (rd_idx),
        .rd  (bank1_rd)
    );

    // Address 0 is the bias input; the network walks past the image at the end.
    always_comb begin
        if (bus.rd_adr == '0) begin
            bus.rd_byte = BIAS_BYTE;
        end else if (bus.rd_adr <= ADR_LEN'(NUM_PIX)) begin
            bus.rd_byte = rd_bank_q ? bank1_rd : bank0_rd;
        end else begin
            bus.rd_byte = 8'h00;
        end
    end

    assign bus.pix_ready = pix_ready_q;
    assign bus.nn_start  = nn_start_q;
    assign bus.busy      = busy_q;

`ifdef FRAME_STATS_EN
    logic [15:0] frames_done_q, frames_done_d;
    logic [7:0]  resyncs_q, resyncs_d;
    logic [7:0]  drops_q, drops_d;

    always_comb begin
        frames_done_d = frames_done_q;
        resyncs_d     = resyncs_q;
        drops_d       = drops_q;
        if (swap && (frames_done_q != '1)) begin
            frames_done_d = frames_done_q + 16'd1;
        end
        if ((state_q == FILL) && accept && bus.pix_sof && (resyncs_q != '1)) begin
            resyncs_d = resyncs_q + 8'd1;
        end
        if ((state_q == IDLE) && accept && !bus.pix_sof && (drops_q != '1)) begin
            drops_d = drops_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frames_done_q <= '0;
            resyncs_q     <= '0;
            drops_q       <= '0;
        end else begin
            frames_done_q <= frames_done_d;
            resyncs_q     <= resyncs_d;
            drops_q       <= drops_d;
        end
    end

    assign frames_done = frames_done_q;
    assign resyncs     = resyncs_q;
    assign drops       = drops_q;
`endif

endmodule

// File: tb/tb_img_frame_buffer.sv
module tb_img_frame_buffer;
    import img_frame_buffer_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    img_frame_buffer_if bus ();

`ifdef FRAME_STATS_EN
    logic [15:0] frames_done;
    logic [7:0]  resyncs;
    logic [7:0]  drops;
`endif

    img_frame_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef FRAME_STATS_EN
        ,
        .frames_done (frames_done),
        .resyncs     (resyncs),
        .drops       (drops)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Streams n back-to-back pixels; data = base+i or base-i.
    task automatic send_frame(input int n, input logic [7:0] base, input bit down,
                              input bit sof_first, input bit done_last);
        for (int i = 0; i < n; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_sof   = sof_first && (i == 0);
            bus.pix_data  = down ? 8'(base - 8'(i)) : 8'(base + 8'(i));
            bus.nn_done   = done_last && (i == n - 1);
            @(posedge clk);
            #1;
        end
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.nn_done   = 1'b0;
    endtask

    task automatic pulse_done();
        bus.nn_done = 1'b1;
        @(posedge clk);
        #1;
        bus.nn_done = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [ADR_LEN-1:0] adr, input logic [7:0] exp);
        bus.rd_adr = adr;
        #1;
        total++;
        if (bus.rd_byte !== exp) begin
            bad++;
            $display("FAIL %s: rd_adr=%0d got %h expected %h", name, adr, bus.rd_byte, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_data  = 8'h00;
        bus.rd_adr    = '0;
        bus.nn_done   = 1'b0;
        #12;
        total++;
        if ({bus.busy, bus.nn_start, bus.pix_ready} !== 3'b001) begin
            bad++;
            $display("FAIL reset_outputs: busy/start/ready=%b expected 001",
                     {bus.busy, bus.nn_start, bus.pix_ready});
        end
        reset = 1'b0;
    endtask

    task automatic test_first_frame();
        send_frame(256, 8'h00, 1'b0, 1'b1, 1'b0);
        total++;
        if ({bus.nn_start, bus.pix_ready, bus.busy} !== 3'b000) begin
            bad++;
            $display("FAIL f1_last_write: start/ready/busy=%b expected 000",
                     {bus.nn_start, bus.pix_ready, bus.busy});
        end
        @(posedge clk); #1;
        total++;
        if ({bus.nn_start, bus.busy} !== 2'b11) begin
            bad++;
            $display("FAIL f1_swap: start/busy=%b expected 11", {bus.nn_start, bus.busy});
        end
        @(posedge clk); #1;
        total++;
        if ({bus.nn_start, bus.busy, bus.pix_ready} !== 3'b011) begin
            bad++;
            $display("FAIL f1_strobe_len: start/busy/ready=%b expected 011",
                     {bus.nn_start, bus.busy, bus.pix_ready});
        end
        rd_chk("f1_bias", 9'd0, 8'hFF);
        rd_chk("f1_adr1", 9'd1, 8'h00);
        rd_chk("f1_adr100", 9'd100, 8'd99);
        rd_chk("f1_adr256", 9'd256, 8'hFF);
        rd_chk("f1_adr257", 9'd257, 8'h00);
        rd_chk("f1_adr300", 9'd300, 8'h00);
    endtask

    task automatic test_fill_while_busy();
        send_frame(128, 8'hFF, 1'b1, 1'b1, 1'b0);
        rd_chk("f2_mid_old", 9'd50, 8'd49);
        send_frame(128, 8'h7F, 1'b1, 1'b0, 1'b0);
        total++;
        if (bus.pix_ready !== 1'b0) begin
            bad++;
            $display("FAIL f2_ready_drop: pix_ready=%b expected 0", bus.pix_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.nn_start, bus.busy, bus.pix_ready} !== 3'b010) begin
            bad++;
            $display("FAIL f2_no_swap: start/busy/ready=%b expected 010",
                     {bus.nn_start, bus.busy, bus.pix_ready});
        end
        rd_chk("f2_old_adr50", 9'd50, 8'd49);
        rd_chk("f2_old_adr256", 9'd256, 8'hFF);
        pulse_done();
        total++;
        if ({bus.nn_start, bus.busy} !== 2'b00) begin
            bad++;
            $display("FAIL f2_done_clear: start/busy=%b expected 00", {bus.nn_start, bus.busy});
        end
        @(posedge clk); #1;
        total++;
        if ({bus.nn_start, bus.busy, bus.pix_ready} !== 3'b111) begin
            bad++;
            $display("FAIL f2_swap: start/busy/ready=%b expected 111",
                     {bus.nn_start, bus.busy, bus.pix_ready});
        end
        rd_chk("f2_adr1", 9'd1, 8'hFF);
        rd_chk("f2_adr2", 9'd2, 8'hFE);
        rd_chk("f2_adr256", 9'd256, 8'h00);
    endtask

    task automatic test_junk_then_frame();
        pulse_done();
        send_frame(3, 8'hAA, 1'b0, 1'b0, 1'b0);
        send_frame(256, 8'h03, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        total++;
        if ({bus.nn_start, bus.busy} !== 2'b11) begin
            bad++;
            $display("FAIL f3_swap: start/busy=%b expected 11", {bus.nn_start, bus.busy});
        end
        rd_chk("f3_adr1", 9'd1, 8'h03);
        rd_chk("f3_adr256", 9'd256, 8'h02);
`ifdef FRAME_STATS_EN
        total++;
        if (drops !== 8'd3) begin
            bad++;
            $display("FAIL f3_drops: got %0d expected 3", drops);
        end
`endif
    endtask

    task automatic test_resync();
        pulse_done();
        send_frame(100, 8'h11, 1'b0, 1'b1, 1'b0);
        send_frame(256, 8'h40, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        total++;
        if ({bus.nn_start, bus.busy} !== 2'b11) begin
            bad++;
            $display("FAIL f4_swap: start/busy=%b expected 11", {bus.nn_start, bus.busy});
        end
        rd_chk("f4_adr1", 9'd1, 8'h40);
        rd_chk("f4_adr101", 9'd101, 8'hA4);
        rd_chk("f4_adr256", 9'd256, 8'h3F);
`ifdef FRAME_STATS_EN
        total++;
        if (resyncs !== 8'd1 || frames_done !== 16'd4) begin
            bad++;
            $display("FAIL f4_stats: resyncs=%0d frames=%0d expected 1 4", resyncs, frames_done);
        end
`endif
    endtask

    task automatic test_done_on_full_edge();
        send_frame(256, 8'h07, 1'b0, 1'b1, 1'b1);
        total++;
        if ({bus.nn_start, bus.busy, bus.pix_ready} !== 3'b000) begin
            bad++;
            $display("FAIL f5_full_done: start/busy/ready=%b expected 000",
                     {bus.nn_start, bus.busy, bus.pix_ready});
        end
        @(posedge clk); #1;
        total++;
        if ({bus.nn_start, bus.busy} !== 2'b11) begin
            bad++;
            $display("FAIL f5_swap: start/busy=%b expected 11", {bus.nn_start, bus.busy});
        end
        rd_chk("f5_adr256", 9'd256, 8'h06);
        pulse_done();
        pulse_done();
        @(posedge clk); #1;
        total++;
        if ({bus.nn_start, bus.busy, bus.pix_ready} !== 3'b001) begin
            bad++;
            $display("FAIL f5_spurious_done: start/busy/ready=%b expected 001",
                     {bus.nn_start, bus.busy, bus.pix_ready});
        end
        rd_chk("f5_adr1_kept", 9'd1, 8'h07);
    endtask

    task automatic test_reset_mid_op();
        send_frame(256, 8'h99, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        send_frame(50, 8'h55, 1'b0, 1'b1, 1'b0);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL f6_pre_busy: busy=%b expected 1", bus.busy);
        end
        #3;
        reset = 1'b1;
        #1;
        total++;
        if ({bus.busy, bus.nn_start, bus.pix_ready} !== 3'b001) begin
            bad++;
            $display("FAIL f6_async_reset: busy/start/ready=%b expected 001",
                     {bus.busy, bus.nn_start, bus.pix_ready});
        end
        @(posedge clk); #3;
        reset = 1'b0;
        send_frame(256, 8'h33, 1'b0, 1'b1, 1'b0);
        total++;
        if (bus.nn_start !== 1'b0) begin
            bad++;
            $display("FAIL f6_pre_start: nn_start=%b expected 0", bus.nn_start);
        end
        @(posedge clk); #1;
        total++;
        if ({bus.nn_start, bus.busy} !== 2'b11) begin
            bad++;
            $display("FAIL f6_swap: start/busy=%b expected 11", {bus.nn_start, bus.busy});
        end
        rd_chk("f6_adr1", 9'd1, 8'h33);
        rd_chk("f6_adr256", 9'd256, 8'h32);
`ifdef FRAME_STATS_EN
        total++;
        if (frames_done !== 16'd1) begin
            bad++;
            $display("FAIL f6_frames: got %0d expected 1", frames_done);
        end
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_first_frame();
        test_fill_while_busy();
        test_junk_then_frame();
        test_resync();
        test_done_on_full_edge();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
